hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//   Parametrised pipeline hazard controller for the 5-stage core; successor to the combinational hazard unit.
//   Adds a per-register load scoreboard (configurable load latency), priority-correct MEM/WB forwarding,
//   a branch-redirect FSM with programmable flush mask and penalty, and a stall watchdog.
//   Sits beside decode; drives stage enables/flushes and operand-forward muxes for NSRC sources.
// PARAMETERS
//   DATA_W      24       forwarded data width
//   REG_AW      4        register address width (NREGS = 2**REG_AW)
//   NSRC        3        source operands checked per decoded instruction
//   LD_LAT      2        cycles after load leaves EX before its result is forwardable (1..7)
//   NSTAGE      5        pipeline stages receiving a flush (IF=0 .. WB=4)
//   FLUSH_MASK  5'b01110 stages flushed on a taken branch
//   BR_PENALTY  1        cycles the redirect FSM holds the flush (>=1)
//   MAX_STALL   64       continuous stall cycles before watchdog trips
//   ZERO_REG    1        1: register 0 never causes a hazard or forward
// PORTS
//   clk            in   1               core clock
//   rst_n          in   1               asynchronous active-low reset
//   src_addr       in   NSRC*REG_AW     decode-stage source register addresses, packed, src0 at LSBs
//   src_used       in   NSRC            per-source valid (unused sources never hazard/forward)
//   ex_rd          in   REG_AW          EX destination
//   ex_reg_write   in   1               EX instruction writes a register
//   ex_is_load     in   1               EX instruction is a load
//   mem_rd, wb_rd  in   REG_AW          MEM / WB destinations
//   mem_reg_write  in   1               MEM writes a register
//   mem_is_load    in   1               MEM holds a load (data not yet valid)
//   wb_reg_write   in   1               WB writes a register
//   mem_result     in   DATA_W          ALU result in MEM
//   wb_result      in   DATA_W          write-back value
//   branch_taken   in   1               taken branch resolved in EX this cycle
//   stall          out  1               hold IF/ID, bubble into EX
//   flush          out  NSTAGE          per-stage flush
//   fwd_sel        out  NSRC*2          per source: 00 regfile, 01 MEM, 10 WB
//   fwd_data       out  NSRC*DATA_W     forwarded operand per source (don't-care when sel=00)
//   stall_timeout  out  1               sticky watchdog error
//   stall_cycles   out  32              perf: total stalled cycles (optional)
//   flush_events   out  32              perf: taken-branch count (optional)
// BEHAVIOUR
//   Reset: scoreboard all 0, FSM IDLE, stall=0, flush=0, stall_timeout=0, counters 0; fwd_* combinational.
//   Scoreboard: per-register 3-bit countdown. On ex_is_load & ex_reg_write & ~flush[2]: cnt[ex_rd]<=LD_LAT.
//     Other nonzero counters decrement by 1 each cycle. A re-issued load reloads (no accumulate).
//   stall = OR over used sources of (cnt[src]!=0), then masked: forced 0 when flush[1] is asserted.
//     Combinational from current state (0-cycle latency). Scoreboard decrements during stall.
//   Forwarding per used source (ZERO_REG & src==0 -> 00): MEM hit (mem_reg_write & ~mem_is_load & mem_rd==src)
//     wins over WB hit (wb_reg_write & wb_rd==src); otherwise 00. Data mux follows sel.
//   Redirect FSM: IDLE --branch_taken--> FLUSH (flush=FLUSH_MASK same cycle, combinational);
//     FLUSH: hold flush[0] for BR_PENALTY-1 further cycles via counter, then IDLE (BR_PENALTY=1 skips hold).
//     branch_taken while holding restarts the penalty counter and re-asserts full FLUSH_MASK.
//   Watchdog: counter increments on stall, clears on ~stall; reaching MAX_STALL sets stall_timeout (sticky).
//   Reset mid-operation clears all state asynchronously; first post-reset cycle behaves as IDLE/empty.
// CONFIGURATION
//   HAZARD_PERF_CNT_EN defined: stall_cycles (+1 per stall cycle) and flush_events (+1 per branch_taken)
//     are 32-bit saturating counters. Undefined: both outputs tied to 0, no flops inferred.
// STRUCTURE
//   hazard_pkg: fwd_sel_e {FWD_RF,FWD_MEM,FWD_WB}, redir_state_e {IDLE,FLUSH}, stage index constants
//     STG_IF..STG_WB.
//   Sub-module hazard_scoreboard (NREGS countdown array, issue/decrement, NSRC busy lookup); rest flat.
// TESTING
//   Load r3 in EX (LD_LAT=2), next decode reads r3 -> stall=1 two cycles, then fwd_sel=10, data=wb_result.
//   mem_rd=wb_rd=r5, both write, src0=r5 -> fwd_sel=01, fwd_data=mem_result (MEM priority).
//   src1=r0 with mem_rd=r0 writing, ZERO_REG=1 -> fwd_sel=00, stall=0.
//   branch_taken with load-use pending -> flush=01110, stall=0 that cycle; BR_PENALTY=3 -> flush[0] 2 more cycles.
//   Force 64 continuous stalls (MAX_STALL=64) -> stall_timeout=1, stays 1 after stall clears until rst_n low.
//   With HAZARD_PERF_CNT_EN: 3 branches, 5 stalls -> flush_events=3, stall_cycles=5; without, both 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard controller: forward-mux encodings,
// redirect FSM states, pipeline stage indices.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } redir_state_e;

    localparam int unsigned STG_IF  = 0;
    localparam int unsigned STG_ID  = 1;
    localparam int unsigned STG_EX  = 2;
    localparam int unsigned STG_MEM = 3;
    localparam int unsigned STG_WB  = 4;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/pipeline-side bundle of the hazard controller; the pipeline is the
// master, hazard_ctrl is the slave.
interface hazard_ctrl_if #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned REG_AW = 4,
    parameter int unsigned NSRC   = 3,
    parameter int unsigned NSTAGE = 5
);
    logic [NSRC*REG_AW-1:0] src_addr;
    logic [NSRC-1:0]        src_used;
    logic [REG_AW-1:0]      ex_rd;
    logic                   ex_reg_write;
    logic                   ex_is_load;
    logic [REG_AW-1:0]      mem_rd;
    logic [REG_AW-1:0]      wb_rd;
    logic                   mem_reg_write;
    logic                   mem_is_load;
    logic                   wb_reg_write;
    logic [DATA_W-1:0]      mem_result;
    logic [DATA_W-1:0]      wb_result;
    logic                   branch_taken;
    logic                   stall;
    logic [NSTAGE-1:0]      flush;
    logic [NSRC*2-1:0]      fwd_sel;
    logic [NSRC*DATA_W-1:0] fwd_data;
    logic                   stall_timeout;
    logic [31:0]            stall_cycles;
    logic [31:0]            flush_events;

    modport master (
        output src_addr, src_used, ex_rd, ex_reg_write, ex_is_load,
               mem_rd, wb_rd, mem_reg_write, mem_is_load, wb_reg_write,
               mem_result, wb_result, branch_taken,
        input  stall, flush, fwd_sel, fwd_data, stall_timeout,
               stall_cycles, flush_events
    );

    modport slave (
        input  src_addr, src_used, ex_rd, ex_reg_write, ex_is_load,
               mem_rd, wb_rd, mem_reg_write, mem_is_load, wb_reg_write,
               mem_result, wb_result, branch_taken,
        output stall, flush, fwd_sel, fwd_data, stall_timeout,
               stall_cycles, flush_events
    );

endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register load-latency countdown array with busy lookup for the decode
// sources; register 0 can be excluded from hazards via ZERO_REG.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = 4,
    parameter int unsigned NSRC     = 3,
    parameter int unsigned LD_LAT   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   issue_i,
    input  logic [REG_AW-1:0]      issue_rd_i,
    input  logic [NSRC*REG_AW-1:0] src_addr_i,
    input  logic [NSRC-1:0]        src_used_i,
    output logic                   busy_o
);
    localparam int unsigned NREGS = 2**REG_AW;

    logic [2:0]        cnt_q [NREGS];
    logic [2:0]        cnt_d [NREGS];
    logic [REG_AW-1:0] src;

    // A re-issued load overrides the running count rather than adding to it.
    always_comb begin
        for (int unsigned r = 0; r < NREGS; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - 3'd1 : '0;
            if (issue_i && issue_rd_i == REG_AW'(r)) cnt_d[r] = 3'(LD_LAT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREGS; r++) cnt_q[r] <= '0;
        end else begin
            for (int unsigned r = 0; r < NREGS; r++) cnt_q[r] <= cnt_d[r];
        end
    end

    always_comb begin
        busy_o = 1'b0;
        src    = '0;
        for (int unsigned s = 0; s < NSRC; s++) begin
            src = src_addr_i[s*REG_AW +: REG_AW];
            if (src_used_i[s] && cnt_q[src] != '0 && !(ZERO_REG != 0 && src == '0))
                busy_o = 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load scoreboard stall, MEM/WB forwarding, branch
// redirect flush FSM, stall watchdog. Optional perf counters: HAZARD_PERF_CNT_EN.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned       DATA_W     = 24,
    parameter int unsigned       REG_AW     = 4,
    parameter int unsigned       NSRC       = 3,
    parameter int unsigned       LD_LAT     = 2,
    parameter int unsigned       NSTAGE     = 5,
    parameter logic [NSTAGE-1:0] FLUSH_MASK = 5'b01110,
    parameter int unsigned       BR_PENALTY = 1,
    parameter int unsigned       MAX_STALL  = 64,
    parameter int unsigned       ZERO_REG   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    hazard_ctrl_if.slave bus
);
    localparam int unsigned PEN_W = (BR_PENALTY > 1) ? $clog2(BR_PENALTY) : 1;
    localparam int unsigned WD_W  = $clog2(MAX_STALL + 1);

    logic                   busy;
    logic                   stall;
    logic [NSTAGE-1:0]      flush;
    redir_state_e           state_q;
    logic [PEN_W-1:0]       pen_q;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic                   to_q, to_d;
    logic [NSRC*2-1:0]      fwd_sel_v;
    logic [NSRC*DATA_W-1:0] fwd_data_v;
    logic [REG_AW-1:0]      src;
    fwd_sel_e               sel;

    hazard_scoreboard #(
        .REG_AW   (REG_AW),
        .NSRC     (NSRC),
        .LD_LAT   (LD_LAT),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_i    (bus.ex_is_load & bus.ex_reg_write & ~flush[STG_EX]),
        .issue_rd_i (bus.ex_rd),
        .src_addr_i (bus.src_addr),
        .src_used_i (bus.src_used),
        .busy_o     (busy)
    );

    // Full mask on the resolving cycle, then only IF is held during the penalty.
    always_comb begin
        flush = '0;
        if (bus.branch_taken)    flush = FLUSH_MASK;
        else if (state_q == FLUSH) flush[STG_IF] = 1'b1;
    end

    assign stall = busy & ~flush[STG_ID];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pen_q   <= '0;
        end else if (bus.branch_taken) begin
            if (BR_PENALTY > 1) begin
                state_q <= FLUSH;
                pen_q   <= PEN_W'(BR_PENALTY - 1);
            end else begin
                state_q <= IDLE;
                pen_q   <= '0;
            end
        end else if (state_q == FLUSH) begin
            if (pen_q == PEN_W'(1)) begin
                state_q <= IDLE;
                pen_q   <= '0;
            end else begin
                pen_q   <= pen_q - 1'b1;
            end
        end
    end

    always_comb begin
        wd_d = '0;
        if (stall) wd_d = (wd_q == WD_W'(MAX_STALL)) ? wd_q : wd_q + 1'b1;
        to_d = to_q | (wd_d == WD_W'(MAX_STALL));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            to_q <= to_d;
        end
    end

    always_comb begin
        fwd_sel_v  = '0;
        fwd_data_v = '0;
        src        = '0;
        sel        = FWD_RF;
        for (int unsigned s = 0; s < NSRC; s++) begin
            src = bus.src_addr[s*REG_AW +: REG_AW];
            sel = FWD_RF;
            if (bus.src_used[s] && !(ZERO_REG != 0 && src == '0)) begin
                if (bus.mem_reg_write && !bus.mem_is_load && bus.mem_rd == src) sel = FWD_MEM;
                else if (bus.wb_reg_write && bus.wb_rd == src)                  sel = FWD_WB;
            end
            fwd_sel_v[2*s +: 2] = sel;
            case (sel)
                FWD_MEM: fwd_data_v[s*DATA_W +: DATA_W] = bus.mem_result;
                FWD_WB:  fwd_data_v[s*DATA_W +: DATA_W] = bus.wb_result;
                default: ;
            endcase
        end
    end

    assign bus.stall         = stall;
    assign bus.flush         = flush;
    assign bus.fwd_sel       = fwd_sel_v;
    assign bus.fwd_data      = fwd_data_v;
    assign bus.stall_timeout = to_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall)            stall_cnt_q <= sat_inc32(stall_cnt_q);
            if (bus.branch_taken) flush_cnt_q <= sat_inc32(flush_cnt_q);
        end
    end

    assign bus.stall_cycles = stall_cnt_q;
    assign bus.flush_events = flush_cnt_q;
`else
    assign bus.stall_cycles = '0;
    assign bus.flush_events = '0;
`endif

endmodule
